// File: rtl/pll_reset_seq_if.sv
// pll_reset_seq_if
// Bundles the PLL-facing and downstream-facing signals of the PLL reset
// sequencer so they travel as one port.
//   pll_locked  - PLL LOCK output, asynchronous to the sequencer clock
//   pll_rst     - active-high PLL reset
//   sys_rstb    - active-low downstream reset
//   ready       - high while the sequencer is in RUN
//   lost_count  - saturating count of lock losses seen in RUN
//   retry_count - saturating count of lock-wait timeouts
// master: the sequencer side. slave: the PLL / downstream side.
interface pll_reset_seq_if #(
  parameter int CNT_W = 8
);
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rstb;
  logic             ready;
  logic [CNT_W-1:0] lost_count;
  logic [CNT_W-1:0] retry_count;

  modport master (
    input  pll_locked,
    output pll_rst,
    output sys_rstb,
    output ready,
    output lost_count,
    output retry_count
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  sys_rstb,
    input  ready,
    input  lost_count,
    input  retry_count
  );
endinterface

// File: rtl/pll_reset_seq.sv
// pll_reset_seq
// Sequences the pixel-clock PLL out of reset in the reference clock domain:
// holds the PLL in reset, waits for lock, requires lock to stay stable for
// LOCK_CYCLES, then releases the downstream reset. Lock loss in RUN or a
// lock-wait timeout re-sequences from HOLD.
//   clk   - reference clock
//   rstb  - asynchronous active-low reset
//   bus   - pll_reset_seq_if.master (pll_locked in; pll_rst, sys_rstb,
//           ready, lost_count, retry_count out)
// All outputs are registered and decoded from the next state, so they
// change on the same edge as the state register.
module pll_reset_seq #(
  parameter int RST_CYCLES     = 16,
  parameter int LOCK_CYCLES    = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rstb,
  pll_reset_seq_if.master  bus
);

  // The shared cycle counter only ever has to hold N-1 for the largest N.
  localparam int MAX_AB  = (RST_CYCLES > LOCK_CYCLES) ? RST_CYCLES : LOCK_CYCLES;
  localparam int MAX_CYC = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          cyc;
  logic [CW-1:0]          cyc_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   lost_inc;
  logic                   retry_inc;
  logic                   pll_rst_q;
  logic                   sys_rstb_q;
  logic                   ready_q;
  logic [CNT_W-1:0]       lost_q;
  logic [CNT_W-1:0]       retry_q;

  // Lock synchronizer; only the last stage is visible to the FSM.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Next-state logic. The cycle counter restarts on every state change,
  // so a state entered at edge E is left at edge E+N when cyc reaches N-1.
  // In WAIT_LOCK the lock test comes first, so lock beats a same-cycle
  // timeout.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc + 1'b1;
    lost_inc  = 1'b0;
    retry_inc = 1'b0;
    case (state)
      HOLD: begin
        if (cyc == RST_LAST) begin
          state_nxt = WAIT_LOCK;
          cyc_nxt   = '0;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt = STABLE;
          cyc_nxt   = '0;
        end else if (cyc == TO_LAST) begin
          state_nxt = HOLD;
          cyc_nxt   = '0;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cyc_nxt   = '0;
        end else if (cyc == LOCK_LAST) begin
          state_nxt = RUN;
          cyc_nxt   = '0;
        end
      end
      RUN: begin
        cyc_nxt = '0;
        if (!lock_s) begin
          state_nxt = HOLD;
          lost_inc  = 1'b1;
        end
      end
      default: begin
        state_nxt = HOLD;
        cyc_nxt   = '0;
      end
    endcase
  end

  // State, counter and registered outputs. Outputs are decoded from
  // state_nxt so they line up with the state register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= HOLD;
      cyc        <= '0;
      pll_rst_q  <= 1'b1;
      sys_rstb_q <= 1'b0;
      ready_q    <= 1'b0;
      lost_q     <= '0;
      retry_q    <= '0;
    end else begin
      state      <= state_nxt;
      cyc        <= cyc_nxt;
      pll_rst_q  <= (state_nxt == HOLD);
      sys_rstb_q <= (state_nxt == RUN);
      ready_q    <= (state_nxt == RUN);
      if (lost_inc && (lost_q != {CNT_W{1'b1}})) begin
        lost_q <= lost_q + 1'b1;
      end
      if (retry_inc && (retry_q != {CNT_W{1'b1}})) begin
        retry_q <= retry_q + 1'b1;
      end
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rstb    = sys_rstb_q;
  assign bus.ready       = ready_q;
  assign bus.lost_count  = lost_q;
  assign bus.retry_count = retry_q;

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Controls the pixel-clock PLL's reset input and consumes its lock output.
- Holds the PLL in reset at power-up, then releases it and waits for a lock that stays stable.
- Deasserts the downstream reset only once lock is stable; re-sequences on lock loss or lock timeout.
- Runs in the reference clock domain, upstream of all pixclk-domain logic.

Parameters:
- RST_CYCLES, 16: cycles pll_rst is held high per HOLD visit (>=1).
- LOCK_CYCLES, 1024: consecutive synchronized-lock cycles required before release (>=1).
- TIMEOUT_CYCLES, 65536: max WAIT_LOCK cycles before retry (>=1).
- SYNC_STAGES, 2: synchronizer flops on pll_locked (>=2).
- CNT_W, 8: width of the status counters.

Ports:
- clk  in  1  reference clock (PLL REFERENCECLK source).
- rstb  in  1  asynchronous active-low reset.
- pll_locked  in  1  PLL LOCK output, asynchronous to clk.
- pll_rst  out  1  active-high PLL reset, drives the PLL rst input.
- sys_rstb  out  1  active-low downstream reset; asserts asynchronously with rstb, deasserts synchronously to clk.
- ready  out  1  high only in RUN.
- lost_count  out  CNT_W  saturating count of lock losses seen in RUN.
- retry_count  out  CNT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- Reset (rstb=0, async):
  - state=HOLD, all counters 0, synchronizer cleared.
  - pll_rst=1, sys_rstb=0, ready=0, lost_count=0, retry_count=0.
- All outputs are registered, decoded from next-state, so they change on the same edge as the state.
- lock_s = pll_locked passed through SYNC_STAGES flops. The FSM uses only lock_s.
- One shared cycle counter, cleared on every state entry. Width is clog2 of the largest of RST_CYCLES, LOCK_CYCLES and TIMEOUT_CYCLES.
- HOLD: pll_rst=1, sys_rstb=0, ready=0.
  - Stays exactly RST_CYCLES cycles, then moves to WAIT_LOCK. lock_s is ignored.
- WAIT_LOCK: pll_rst=0, sys_rstb=0.
  - lock_s=1 -> STABLE on the next edge.
  - Else, after TIMEOUT_CYCLES cycles in the state -> HOLD, retry_count+1 (saturating).
  - If lock_s=1 and the timeout expire on the same cycle, lock wins.
- STABLE: pll_rst=0, sys_rstb=0.
  - lock_s=0 on any cycle -> WAIT_LOCK with the timeout counter restarted. This is not a retry, and no counter increments.
  - After LOCK_CYCLES consecutive cycles with lock_s=1 -> RUN. RUN entry edge = STABLE entry edge + LOCK_CYCLES.
- RUN: pll_rst=0, sys_rstb=1, ready=1.
  - lock_s=0 -> HOLD. On that same edge: sys_rstb=0, ready=0, pll_rst=1, lost_count+1 (saturating).
- Saturation: counters stick at 2^CNT_W-1 and never wrap.
- Async reset mid-sequence: immediate return to reset values, including clearing both status counters.
- Glitch rule: a pll_locked pulse shorter than one clk period may or may not be seen. Any pulse that is seen is handled by the rules above.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: RST_CYCLES=4, LOCK_CYCLES=8, TIMEOUT_CYCLES=20, SYNC_STAGES=2, CNT_W=2.)
1. Normal bring-up: release rstb at edge 0, pll_locked=1 from edge 6 -> pll_rst high for edges 0-3 and low from edge 4; STABLE entered at edge 8; sys_rstb=1 and ready=1 at edge 16; both counters 0.
2. Lock glitch in STABLE: drop pll_locked for 3 cycles at STABLE+3 -> returns to WAIT_LOCK; RUN reached only after 8 further consecutive lock cycles; retry_count=0; sys_rstb never high during the glitch.
3. No lock: pll_locked held 0 -> pll_rst pulses high for 4 cycles every 24 cycles; retry_count counts 1, 2, 3, then stays at 3 (saturated); sys_rstb stays 0.
4. Lock loss in RUN: from RUN, drop pll_locked -> 2 edges later sys_rstb=0, ready=0, pll_rst=1, lost_count=1; restoring lock leads to RUN again after HOLD, WAIT_LOCK and 8 STABLE cycles.
5. Async reset in RUN with lost_count=2: assert rstb mid-cycle -> sys_rstb=0 and pll_rst=1 without waiting for a clk edge; lost_count=0 and retry_count=0; after release the full sequence of test 1 repeats.
6. Simultaneous events: lock_s rising on the exact cycle the WAIT_LOCK timeout expires -> moves to STABLE, retry_count unchanged.
